// File: rtl/av2_mv_symbol_encoder.sv
// MV symbol encoder: serialises one signed (mv_x, mv_y) pair into context-tagged
// symbols (ZERO, SIGN, CLASS, BITS per component) in MV-decoder consumption order.
module av2_mv_symbol_encoder #(
    parameter int MV_W     = 16,
    parameter int CLS_W    = 4,
    parameter int CTX_BASE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [MV_W-1:0] mv_x,
    input  logic [MV_W-1:0] mv_y,
    input  logic            mv_valid,
    output logic            mv_ready,
    output logic [15:0]     symbol,
    output logic [15:0]     symbol_ctx,
    output logic            symbol_valid,
    input  logic            symbol_ready,
    output logic            busy,
    output logic            done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ZERO  = 3'd1;
    localparam logic [2:0] S_SIGN  = 3'd2;
    localparam logic [2:0] S_CLASS = 3'd3;
    localparam logic [2:0] S_BITS  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             comp_q, comp_d;
    logic [MV_W-1:0]  mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [MV_W-1:0]  y_q, y_d;
    logic [CLS_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [CLS_W-1:0] cls_c;
    logic [1:0]       typ_c;
    logic             hs;
    logic             adv;

    // Most-negative input maps to 2^(MV_W-1), which still fits unsigned.
    function automatic logic [MV_W-1:0] mag_of(input logic [MV_W-1:0] v);
        return v[MV_W-1] ? (~v + MV_W'(1)) : v;
    endfunction

    always_comb begin
        cls_c = '0;
        for (int i = 0; i < MV_W; i++) begin
            if (mag_q[i]) cls_c = CLS_W'(i);
        end
    end

    assign hs           = symbol_valid & symbol_ready;
    assign mv_ready     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign symbol_valid = busy;
    assign done         = done_q;

    always_comb begin
        state_d = state_q;
        comp_d  = comp_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mv_valid) begin
                    state_d = S_ZERO;
                    comp_d  = 1'b0;
                    neg_d   = mv_x[MV_W-1];
                    mag_d   = mag_of(mv_x);
                    y_d     = mv_y;
                end
            end
            S_ZERO: begin
                if (hs) begin
                    if (mag_q == '0) adv = 1'b1;
                    else             state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                if (hs) state_d = S_CLASS;
            end
            S_CLASS: begin
                if (hs) begin
                    if (cls_c == '0) begin
                        adv = 1'b1;
                    end else begin
                        state_d = S_BITS;
                        cnt_d   = cls_c - CLS_W'(1);
                    end
                end
            end
            S_BITS: begin
                if (hs) begin
                    if (cnt_q == '0) adv = 1'b1;
                    else             cnt_d = cnt_q - CLS_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (adv) begin
            if (!comp_q) begin
                comp_d  = 1'b1;
                neg_d   = y_q[MV_W-1];
                mag_d   = mag_of(y_q);
                state_d = S_ZERO;
            end else begin
                comp_d  = 1'b0;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_comb begin
        symbol = '0;
        typ_c  = 2'd0;
        case (state_q)
            S_ZERO:  begin symbol[0] = (mag_q == '0);   typ_c = 2'd0; end
            S_SIGN:  begin symbol[0] = neg_q;           typ_c = 2'd1; end
            S_CLASS: begin symbol[CLS_W-1:0] = cls_c;   typ_c = 2'd2; end
            S_BITS:  begin symbol[0] = mag_q[cnt_q];    typ_c = 2'd3; end
            default: begin symbol = '0;                 typ_c = 2'd0; end
        endcase
        if (state_q == S_IDLE) symbol_ctx = 16'(CTX_BASE);
        else                   symbol_ctx = 16'(CTX_BASE) + {13'd0, comp_q, typ_c};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            comp_q  <= 1'b0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            y_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_av2_mv_symbol_encoder.sv
// Testbench for av2_mv_symbol_encoder: random and directed MVs checked against
// a symbol-list reference model built from the encoding rules.
module tb_av2_mv_symbol_encoder;

    localparam int MV_W     = 16;
    localparam int CLS_W    = 4;
    localparam int CTX_BASE = 8;

    logic        clk;
    logic        rst;
    logic [15:0] mv_x;
    logic [15:0] mv_y;
    logic        mv_valid;
    logic        mv_ready;
    logic [15:0] symbol;
    logic [15:0] symbol_ctx;
    logic        symbol_valid;
    logic        symbol_ready;
    logic        busy;
    logic        done;

    int passed;
    int total;
    int exp_sym[$];
    int exp_ctx[$];

    av2_mv_symbol_encoder #(
        .MV_W(MV_W), .CLS_W(CLS_W), .CTX_BASE(CTX_BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .mv_x(mv_x), .mv_y(mv_y), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .symbol(symbol), .symbol_ctx(symbol_ctx),
        .symbol_valid(symbol_valid), .symbol_ready(symbol_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_comp(input int v, input int comp);
        int mag;
        int c;
        int base;
        base = CTX_BASE + comp * 4;
        if (v == 0) begin
            exp_sym.push_back(1); exp_ctx.push_back(base);
            return;
        end
        exp_sym.push_back(0); exp_ctx.push_back(base);
        exp_sym.push_back(v < 0 ? 1 : 0); exp_ctx.push_back(base + 1);
        mag = (v < 0) ? -v : v;
        c = 0;
        while ((mag >> (c + 1)) != 0) c++;
        exp_sym.push_back(c); exp_ctx.push_back(base + 2);
        for (int k = c - 1; k >= 0; k--) begin
            exp_sym.push_back((mag >> k) & 1); exp_ctx.push_back(base + 3);
        end
    endtask

    // Entered and left on a falling edge; leaves the bench in the done cycle.
    // rmode: 0 always ready, 1 random ready, 2 three-cycle stall at symbol 2.
    task automatic run_mv(input logic [15:0] x, input logic [15:0] y,
                          input int rmode, input bit hold);
        int n;
        int idx;
        int cyc;
        int stall;
        exp_sym.delete();
        exp_ctx.delete();
        model_comp(int'($signed(x)), 0);
        model_comp(int'($signed(y)), 1);
        n = exp_sym.size();
        total++;
        if (mv_ready !== 1'b1) begin
            $display("FAIL mv_ready_idle: got %b want 1", mv_ready);
        end else passed++;
        mv_x = x; mv_y = y; mv_valid = 1'b1;
        @(negedge clk);
        if (!hold) mv_valid = 1'b0;
        total++;
        if ({symbol_valid, busy, mv_ready} !== 3'b110) begin
            $display("FAIL capture_latency: valid/busy/mv_ready got %b want 110",
                     {symbol_valid, busy, mv_ready});
        end else passed++;
        idx = 0; cyc = 0; stall = 0;
        while (idx < n && cyc < 1000) begin
            case (rmode)
                0: symbol_ready = 1'b1;
                1: symbol_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (idx == 2 && stall < 3) begin
                        symbol_ready = 1'b0; stall++;
                    end else symbol_ready = 1'b1;
                end
            endcase
            if (hold) begin mv_x = 16'($urandom); mv_y = 16'($urandom); end
            total++;
            if ({symbol_valid, busy, mv_ready, done} !== 4'b1100) begin
                $display("FAIL stream_ctrl[%0d]: valid/busy/mv_ready/done got %b want 1100",
                         idx, {symbol_valid, busy, mv_ready, done});
            end else passed++;
            total++;
            if (symbol !== 16'(exp_sym[idx]) || symbol_ctx !== 16'(exp_ctx[idx])) begin
                $display("FAIL symbol[%0d] ready=%b: got sym=%0d ctx=%0d want sym=%0d ctx=%0d",
                         idx, symbol_ready, symbol, symbol_ctx, exp_sym[idx], exp_ctx[idx]);
            end else passed++;
            if (symbol_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        total++;
        if (idx < n) begin
            $display("FAIL stream_timeout: got %0d symbols want %0d", idx, n);
        end else passed++;
        total++;
        if ({done, busy, mv_ready, symbol_valid} !== 4'b1010) begin
            $display("FAIL done_pulse: done/busy/mv_ready/valid got %b want 1010",
                     {done, busy, mv_ready, symbol_valid});
        end else passed++;
        symbol_ready = 1'b0;
    endtask

    task automatic check_idle(input string name);
        total++;
        if (mv_ready !== 1'b1 || symbol !== 16'd0 || symbol_ctx !== 16'(CTX_BASE) ||
            symbol_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL %s: rdy=%b sym=%0d ctx=%0d val=%b busy=%b done=%b want 1 0 %0d 0 0 0",
                     name, mv_ready, symbol, symbol_ctx, symbol_valid, busy, done, CTX_BASE);
        end else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; mv_valid = 1'b0; mv_x = '0; mv_y = '0; symbol_ready = 1'b0;
        @(negedge clk);
        check_idle("reset_values");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle_after_reset");
    endtask

    task automatic test_directed();
        run_mv(16'd0, 16'd0, 0, 1'b0);
        @(negedge clk);
        check_idle("done_single_cycle");
        run_mv(16'd4, 16'hFFFE, 0, 1'b0);
        run_mv(16'h8000, 16'd1, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        run_mv(16'd100, 16'hFFF6, 2, 1'b0);
        run_mv(16'h7FFF, 16'hFFFF, 1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_mv(16'd3, 16'hFFFD, 0, 1'b1);
        run_mv(16'd0, 16'd77, 1, 1'b1);
        run_mv(16'h8000, 16'd0, 0, 1'b1);
        run_mv(16'd1, 16'd2, 1, 1'b0);
        @(negedge clk);
        check_idle("idle_after_b2b");
    endtask

    task automatic test_reset_midstream();
        mv_x = 16'd4; mv_y = 16'hFFFE; mv_valid = 1'b1;
        @(negedge clk);
        mv_valid = 1'b0;
        symbol_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle("async_reset_midstream");
        @(negedge clk);
        rst = 1'b0;
        symbol_ready = 1'b0;
        @(negedge clk);
        check_idle("no_done_after_abort");
        run_mv(16'd0, 16'd0, 0, 1'b0);
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 16'd0;
            1: return 16'h8000;
            2: return 16'($urandom_range(0, 15));
            3: return 16'(-$urandom_range(1, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_mv(pick_val(), pick_val(), int'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)));
        end
        mv_valid = 1'b0;
        @(negedge clk);
        check_idle("idle_after_random");
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
